// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch unit: PC, fixed-latency memory read, IR latch and field decode
module instr_fetch_unit #(
  parameter int unsigned MEM_LAT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch,
  input  logic        pc_load,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic        busy,
  output logic        ir_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_LATCH
  } state_t;

  // Counter preload taken in REQ; WAIT leaves when the count reaches 1,
  // so mem_rd stays high for exactly MEM_LAT cycles (REQ plus WAIT).
  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  state_t      state;
  logic [2:0]  lat_cnt;
  logic [31:0] fetch_addr;

  // Fetch sequencer: state, PC, IR and the registered strobes all move together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      ir         <= 32'h0;
      lat_cnt    <= 3'd0;
      fetch_addr <= RESET_PC;
      mem_rd     <= 1'b0;
      busy       <= 1'b0;
      ir_valid   <= 1'b0;
    end else begin
      ir_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          // A PC load wins over a simultaneous fetch request
          if (pc_load) begin
            pc <= pc_in & ~32'h3;
          end else if (fetch) begin
            state      <= S_REQ;
            fetch_addr <= pc;
            mem_rd     <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_REQ: begin
          lat_cnt <= LAT_LOAD;
          if (MEM_LAT == 1) begin
            state  <= S_LATCH;
            mem_rd <= 1'b0;
            busy   <= 1'b0;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            state  <= S_LATCH;
            mem_rd <= 1'b0;
            busy   <= 1'b0;
          end
        end
        S_LATCH: begin
          ir       <= mem_data_in;
          pc       <= pc + 32'd4;
          ir_valid <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The bus address follows the PC while idle and is frozen for the whole fetch
  assign mem_addr = (state == S_IDLE) ? pc : fetch_addr;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign imm16  = ir[15:0];

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter MEM_LAT, default 2, memory read latency in cycles (legal 1..7) from mem_rd assertion to valid mem_data_in.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port fetch  input  1  request one instruction fetch; sampled only in IDLE.
REQ-006 Port pc_load  input  1  load PC from pc_in.
REQ-007 Port pc_in  input  32  branch/jump target.
REQ-008 Port mem_data_in  input  32  instruction word from memory.
REQ-009 Port mem_addr  output  32  memory read address.
REQ-010 Port mem_rd  output  1  memory read strobe.
REQ-011 Port pc  output  32  current program counter.
REQ-012 Port ir  output  32  latched instruction word.
REQ-013 Port opcode  output  6  ir[31:26].
REQ-014 Port rs, rt, rd  output  5 each  ir[25:21], ir[20:16], ir[15:11].
REQ-015 Port imm16  output  16  ir[15:0]; direct source of the sign-extend stage's 16-bit input.
REQ-016 Port busy  output  1  high in REQ and WAIT.
REQ-017 Port ir_valid  output  1  one-cycle pulse when ir has just been updated.

Function
REQ-018 FSM states IDLE, REQ, WAIT, LATCH; encoding free.
REQ-019 IDLE: fetch=1 -> REQ; otherwise stay.
REQ-020 REQ: one cycle; mem_rd=1, mem_addr=pc; latency counter loaded with MEM_LAT-1; -> WAIT, or -> LATCH directly when MEM_LAT=1.
REQ-021 WAIT: mem_rd=1, mem_addr held at fetch address; counter decrements each cycle; counter reaching 1 -> LATCH.
REQ-022 LATCH: ir <= mem_data_in, pc <= pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), mem_rd=0; -> IDLE.
REQ-023 ir_valid asserted exactly in the cycle after LATCH (ir/pc already updated); fetch to ir_valid latency = MEM_LAT+2 cycles.
REQ-024 Field outputs (opcode, rs, rt, rd, imm16) combinational slices of ir; change only when ir changes.
REQ-025 fetch asserted while not IDLE is ignored, not queued.
REQ-026 pc_load honoured only in IDLE: pc <= pc_in; pc_in[1:0] forced to 00.
REQ-027 pc_load and fetch both high in IDLE: pc takes pc_in, fetch ignored that cycle (stays IDLE).
REQ-028 pc_load while busy or in LATCH ignored; in-flight fetch completes with original address.
REQ-029 mem_addr = pc in IDLE; mem_addr frozen at captured fetch address from REQ through LATCH.
REQ-030 ir never written except in LATCH.

Reset
REQ-031 reset=1 asynchronously forces: state IDLE, pc=RESET_PC, ir=0, counter=0, mem_rd=0, busy=0, ir_valid=0.
REQ-032 Reset during REQ/WAIT/LATCH aborts fetch; no ir update, no ir_valid pulse, pc=RESET_PC.
REQ-033 First fetch accepted on first rising edge after reset deasserts.

Verification
REQ-034 Reset, MEM_LAT=2, fetch pulse, mem_data_in=32'h8D09_AD6A -> mem_rd high 2 cycles at addr 0, ir_valid 4 cycles after fetch, ir=32'h8D09_AD6A, opcode=6'h23, rs=8, rt=9, imm16=16'hAD6A, pc=4.
REQ-035 IDLE, pc_load=1, pc_in=32'h0000_0103 -> pc=32'h0000_0100; next fetch reads mem_addr 32'h0000_0100, pc becomes 32'h0000_0104.
REQ-036 pc_load with pc_in=32'hFFFF_FFFC, fetch, data 32'h2D6A_2D6A -> ir=32'h2D6A_2D6A, imm16=16'h2D6A, pc=0 (wrap).
REQ-037 Fetch, second fetch and pc_load=1 pc_in=32'h40 during WAIT -> exactly one ir_valid, address unchanged, pc=prior+4.
REQ-038 Reset asserted mid-WAIT -> outputs immediately at reset values, no ir_valid, ir stays 0 after release.
REQ-039 MEM_LAT=1 build: fetch -> mem_rd exactly 1 cycle, ir_valid 3 cycles after fetch, back-to-back fetches each complete with pc incrementing by 4.
